ppa_sub16_pipe: RTL and testbench



---
 rtl/ppa_sub16_pipe.sv | 133 +++++++++++++
 tb/tb_ppa_sub16_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppa_sub16_pipe.sv
// Two-stage 16-bit Sklansky prefix subtractor: a - b - bin computed as a + ~b + ~bin,
// prefix levels 1-2 before the mid register, levels 3-4 plus post/flags before the output register.

module ppa_sub16_lvl #(
    parameter int SH = 0
) (
    input  logic [15:0] g_i,
    input  logic [15:0] p_i,
    output logic [15:0] g_o,
    output logic [15:0] p_o
);
    // Index j joins the group ending just below its 2^(SH+1)-aligned half-block.
    for (genvar j = 0; j < 16; j++) begin : g_bit
        localparam int K = ((j >> SH) << SH) - 1;
        if (((j >> SH) & 1) == 1) begin : g_comb
            assign g_o[j] = g_i[j] | (p_i[j] & g_i[K]);
            assign p_o[j] = p_i[j] & p_i[K];
        end else begin : g_pass
            assign g_o[j] = g_i[j];
            assign p_o[j] = p_i[j];
        end
    end
endmodule

module ppa_sub16_pipe (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        bin_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] diff_o,
    output logic        bout_o,
    output logic        ovf_o,
    output logic        zero_o
);
    logic        s1_valid_q, s1_valid_d;
    logic        out_valid_q;
    logic        s2_adv, in_xfer, out_load;

    logic [15:0] nb, p_pre;
    logic [14:0] g_pre;
    logic [15:0] g0, p0, g1, p1, g2_d, p2_d;
    logic [15:0] g2_q, p2_q, p_q;
    logic        a15_q, b15_q;

    logic [15:0] g3, p3, g4;
    logic [15:0] diff_d, diff_q;
    logic        carry, bout_d, ovf_d, zero_d;
    logic        bout_q, ovf_q, zero_q;

    assign s2_adv     = !out_valid_q || out_ready_i;
    assign in_ready_o = rst_ni && (!s1_valid_q || s2_adv);
    assign in_xfer    = in_valid_i && in_ready_o;
    assign out_load   = s2_adv && s1_valid_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (in_xfer)     s1_valid_d = 1'b1;
        else if (s2_adv) s1_valid_d = 1'b0;
    end

    // Prefix index 0 is the borrow-in slot; index i+1 carries bit i.
    assign nb    = ~b_i;
    assign p_pre = a_i ^ nb;
    assign g_pre = a_i[14:0] & nb[14:0];
    assign g0    = {g_pre, ~bin_i};
    assign p0    = {p_pre[14:0], 1'b0};

    ppa_sub16_lvl #(.SH(0)) u_lvl1 (.g_i(g0), .p_i(p0), .g_o(g1),   .p_o(p1));
    ppa_sub16_lvl #(.SH(1)) u_lvl2 (.g_i(g1), .p_i(p1), .g_o(g2_d), .p_o(p2_d));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            g2_q       <= '0;
            p2_q       <= '0;
            p_q        <= '0;
            a15_q      <= 1'b0;
            b15_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_xfer) begin
                g2_q  <= g2_d;
                p2_q  <= p2_d;
                p_q   <= p_pre;
                a15_q <= a_i[15];
                b15_q <= b_i[15];
            end
        end
    end

    ppa_sub16_lvl #(.SH(2)) u_lvl3 (.g_i(g2_q), .p_i(p2_q), .g_o(g3), .p_o(p3));

    // Last level only needs group generate; its propagate has no consumer.
    assign g4[7:0] = g3[7:0];
    for (genvar j = 8; j < 16; j++) begin : g_lvl4
        assign g4[j] = g3[j] | (p3[j] & g3[7]);
    end

    assign diff_d = p_q ^ g4;
    assign carry  = (a15_q & ~b15_q) | (p_q[15] & g4[15]);
    assign bout_d = ~carry;
    assign zero_d = (diff_d == 16'h0000);
    assign ovf_d  = (a15_q != b15_q) && (diff_d[15] != a15_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (out_load) begin
                diff_q <= diff_d;
                bout_q <= bout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign diff_o      = diff_q;
    assign bout_o      = bout_q;
    assign ovf_o       = ovf_q;
    assign zero_o      = zero_q;
endmodule

// File: tb/tb_ppa_sub16_pipe.sv
// Directed and randomized checks of the pipelined prefix subtractor with handshakes.

module tb_ppa_sub16_pipe;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] a_i, b_i;
    logic        bin_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] diff_o;
    logic        bout_o, ovf_o, zero_o;

    int total = 0;
    int bad   = 0;

    ppa_sub16_pipe dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .a_i(a_i), .b_i(b_i), .bin_i(bin_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .diff_o(diff_o), .bout_o(bout_o), .ovf_o(ovf_o), .zero_o(zero_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {out_valid, diff, bout, ovf, zero}
    function automatic logic [19:0] obs();
        return {out_valid_o, diff_o, bout_o, ovf_o, zero_o};
    endfunction

    // Reference result {diff, bout, ovf, zero} from plain subtraction.
    function automatic logic [18:0] ref_sub(logic [15:0] a, logic [15:0] b, logic bin);
        logic [16:0] s;
        logic        bo, ov;
        s  = {1'b0, a} - {1'b0, b} - {16'b0, bin};
        bo = ({1'b0, a} < ({1'b0, b} + {16'b0, bin}));
        ov = (a[15] != b[15]) && (s[15] != a[15]);
        return {s[15:0], bo, ov, (s[15:0] == 16'h0000)};
    endfunction

    // Push one operand through an idle pipeline; returns at the negedge its result is valid.
    task automatic drive_one(input logic [15:0] a, input logic [15:0] b, input logic bin);
        @(negedge clk_i);
        a_i = a; b_i = b; bin_i = bin; in_valid_i = 1'b1; out_ready_i = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        a_i = '0; b_i = '0; bin_i = 1'b0;
        #12;
        total++;
        if ({in_ready_o, obs()} !== 21'h0) begin
            bad++;
            $display("FAIL reset_state: got %h want 0", {in_ready_o, obs()});
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        total++;
        if ({in_ready_o, out_valid_o} !== 2'b10) begin
            bad++;
            $display("FAIL reset_release: in_ready,out_valid=%b want 10", {in_ready_o, out_valid_o});
        end
    endtask

    task automatic test_basic();
        drive_one(16'h1234, 16'h0234, 1'b0);
        total++;
        if (obs() !== {1'b1, 16'h1000, 3'b000}) begin
            bad++; $display("FAIL basic: got %h want %h", obs(), {1'b1, 16'h1000, 3'b000});
        end
        drive_one(16'h0005, 16'h0003, 1'b1);
        total++;
        if (obs() !== {1'b1, 16'h0001, 3'b000}) begin
            bad++; $display("FAIL basic_bin: got %h want %h", obs(), {1'b1, 16'h0001, 3'b000});
        end
    endtask

    task automatic test_borrow_zero();
        drive_one(16'h0000, 16'h0000, 1'b1);
        total++;
        if (obs() !== {1'b1, 16'hFFFF, 3'b100}) begin
            bad++; $display("FAIL borrow_all: got %h want %h", obs(), {1'b1, 16'hFFFF, 3'b100});
        end
        drive_one(16'h8000, 16'h8000, 1'b0);
        total++;
        if (obs() !== {1'b1, 16'h0000, 3'b001}) begin
            bad++; $display("FAIL zero_eq: got %h want %h", obs(), {1'b1, 16'h0000, 3'b001});
        end
        drive_one(16'h0000, 16'hFFFF, 1'b1);
        total++;
        if (obs() !== {1'b1, 16'h0000, 3'b101}) begin
            bad++; $display("FAIL zero_borrow: got %h want %h", obs(), {1'b1, 16'h0000, 3'b101});
        end
        drive_one(16'hFFFF, 16'h0000, 1'b1);
        total++;
        if (obs() !== {1'b1, 16'hFFFE, 3'b000}) begin
            bad++; $display("FAIL max_minus_bin: got %h want %h", obs(), {1'b1, 16'hFFFE, 3'b000});
        end
    endtask

    task automatic test_overflow();
        drive_one(16'h8000, 16'h0001, 1'b0);
        total++;
        if (obs() !== {1'b1, 16'h7FFF, 3'b010}) begin
            bad++; $display("FAIL ovf_neg: got %h want %h", obs(), {1'b1, 16'h7FFF, 3'b010});
        end
        drive_one(16'h7FFF, 16'hFFFF, 1'b0);
        total++;
        if (obs() !== {1'b1, 16'h8000, 3'b110}) begin
            bad++; $display("FAIL ovf_pos: got %h want %h", obs(), {1'b1, 16'h8000, 3'b110});
        end
    endtask

    // 4 operands on consecutive cycles with out_ready high: one result per cycle, in order.
    task automatic test_back_to_back();
        logic [15:0] va [4] = '{16'h0005, 16'h0003, 16'h1000, 16'hABCD};
        logic [15:0] vb [4] = '{16'h0003, 16'h0005, 16'h0001, 16'h1234};
        logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [19:0] ve [4] = '{{1'b1, 16'h0002, 3'b000}, {1'b1, 16'hFFFE, 3'b100},
                                {1'b1, 16'h0FFE, 3'b000}, {1'b1, 16'h9999, 3'b000}};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            out_ready_i = 1'b1;
            if (i < 4) begin
                a_i = va[i]; b_i = vb[i]; bin_i = vc[i]; in_valid_i = 1'b1;
            end else begin
                in_valid_i = 1'b0;
            end
            #1;
            if (i < 4) begin
                total++;
                if (in_ready_o !== 1'b1) begin
                    bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready_o);
                end
            end
            if (i >= 2 && i < 6) begin
                total++;
                if (obs() !== ve[i-2]) begin
                    bad++; $display("FAIL b2b_out[%0d]: got %h want %h", i - 2, obs(), ve[i-2]);
                end
            end
            if (i == 6) begin
                total++;
                if (out_valid_o !== 1'b0) begin
                    bad++; $display("FAIL b2b_empty: out_valid=%b want 0", out_valid_o);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        // ops: 0010-0001=000F, 0020-0001=001F, 0030-0001=002F
        @(negedge clk_i);
        out_ready_i = 1'b0; a_i = 16'h0010; b_i = 16'h0001; bin_i = 1'b0; in_valid_i = 1'b1;
        #1;
        total++;
        if (in_ready_o !== 1'b1) begin bad++; $display("FAIL bp_acc0: in_ready=%b want 1", in_ready_o); end
        @(negedge clk_i);
        a_i = 16'h0020;
        #1;
        total++;
        if (in_ready_o !== 1'b1) begin bad++; $display("FAIL bp_acc1: in_ready=%b want 1", in_ready_o); end
        @(negedge clk_i);
        a_i = 16'h0030;
        #1;
        total++;
        if ({in_ready_o, obs()} !== {1'b0, 1'b1, 16'h000F, 3'b000}) begin
            bad++; $display("FAIL bp_full: got %h want %h", {in_ready_o, obs()}, {1'b0, 1'b1, 16'h000F, 3'b000});
        end
        @(negedge clk_i);
        #1;
        total++;
        if ({in_ready_o, obs()} !== {1'b0, 1'b1, 16'h000F, 3'b000}) begin
            bad++; $display("FAIL bp_hold: got %h want %h", {in_ready_o, obs()}, {1'b0, 1'b1, 16'h000F, 3'b000});
        end
        @(negedge clk_i);
        out_ready_i = 1'b1;
        #1;
        total++;
        if ({in_ready_o, obs()} !== {1'b1, 1'b1, 16'h000F, 3'b000}) begin
            bad++; $display("FAIL bp_release: got %h want %h", {in_ready_o, obs()}, {1'b1, 1'b1, 16'h000F, 3'b000});
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1;
        total++;
        if (obs() !== {1'b1, 16'h001F, 3'b000}) begin
            bad++; $display("FAIL bp_drain1: got %h want %h", obs(), {1'b1, 16'h001F, 3'b000});
        end
        @(negedge clk_i);
        #1;
        total++;
        if (obs() !== {1'b1, 16'h002F, 3'b000}) begin
            bad++; $display("FAIL bp_drain2: got %h want %h", obs(), {1'b1, 16'h002F, 3'b000});
        end
        @(negedge clk_i);
        #1;
        total++;
        if (out_valid_o !== 1'b0) begin bad++; $display("FAIL bp_empty: out_valid=%b want 0", out_valid_o); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk_i);
        out_ready_i = 1'b0; a_i = 16'h4444; b_i = 16'h1111; bin_i = 1'b0; in_valid_i = 1'b1;
        @(negedge clk_i);
        a_i = 16'h5555;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1;
        total++;
        if ({in_ready_o, obs()} !== {1'b0, 1'b1, 16'h3333, 3'b000}) begin
            bad++; $display("FAIL rst_mid_full: got %h want %h", {in_ready_o, obs()}, {1'b0, 1'b1, 16'h3333, 3'b000});
        end
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if ({in_ready_o, obs()} !== 21'h0) begin
            bad++; $display("FAIL rst_mid_clear: got %h want 0", {in_ready_o, obs()});
        end
        @(negedge clk_i);
        rst_ni = 1'b1; out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({in_ready_o, out_valid_o} !== 2'b10) begin
                bad++; $display("FAIL rst_mid_after[%0d]: in_ready,out_valid=%b want 10", i, {in_ready_o, out_valid_o});
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_random(input int n);
        logic [18:0] q[$];
        logic [18:0] e;
        for (int c = 0; c < n + 20; c++) begin
            @(negedge clk_i);
            if (c < n) begin
                in_valid_i  = ($urandom_range(0, 3) != 0);
                out_ready_i = ($urandom_range(0, 3) != 0);
                a_i   = 16'($urandom);
                b_i   = 16'($urandom);
                bin_i = 1'($urandom);
            end else begin
                in_valid_i  = 1'b0;
                out_ready_i = 1'b1;
            end
            #1;
            if (out_valid_o && out_ready_i) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rand_extra: unexpected result %h", obs());
                end else begin
                    e = q.pop_front();
                    if ({diff_o, bout_o, ovf_o, zero_o} !== e) begin
                        bad++; $display("FAIL rand_out: got %h want %h", {diff_o, bout_o, ovf_o, zero_o}, e);
                    end
                end
            end
            if (in_valid_i && in_ready_o) q.push_back(ref_sub(a_i, b_i, bin_i));
        end
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL rand_drain: %0d results missing, want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_zero();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_random(4000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
